// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Packet-level round-robin arbiter sharing one FIFO write port among
//   NUM_REQ requesters. A grant is held from the first beat of a packet until
//   its last beat is written, so packets never interleave in the FIFO.
//   Every packet pays one IDLE arbitration cycle.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req_valid   per-requester beat valid
//   req_data    per-requester beat data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last    per-requester last-beat flag, qualified by req_valid
//   req_ready   per-requester beat accept (only the owner, only while not full)
//   fifo_wen    FIFO write enable
//   fifo_wdata  FIFO write data (owner's data)
//   fifo_full   FIFO full flag (backpressure)
//   grant_id    current owner index, meaningful while busy=1
//   busy        high while a packet owns the write port
//   pkt_count   completed packets, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wen,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    input  logic                          fifo_full,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          pkt_count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t                state_r;
    logic [ID_WIDTH-1:0]   grant_r;
    logic [ID_WIDTH-1:0]   ptr_r;      // last requester that completed a packet
    logic [CNT_WIDTH-1:0]  cnt_r;

    logic [ID_WIDTH-1:0]   pick_s;
    logic                  any_valid_s;
    logic                  owner_valid_s;
    logic                  owner_last_s;
    logic                  beat_s;
    logic [DATA_WIDTH-1:0] data_arr_s [NUM_REQ];

    // (base + offs) mod NUM_REQ; base < NUM_REQ and offs <= NUM_REQ, so one
    // conditional subtraction is enough.
    function automatic logic [ID_WIDTH-1:0] wrap_idx(input logic [ID_WIDTH-1:0] base,
                                                     input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return ID_WIDTH'(sum);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_arr_s[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign owner_valid_s = req_valid[grant_r];
    assign owner_last_s  = req_last[grant_r];
    assign beat_s        = fifo_wen;   // owner valid & owner ready

    // Round-robin search: first valid requester starting just after ptr_r.
    always_comb begin
        pick_s      = '0;
        any_valid_s = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!any_valid_s && req_valid[wrap_idx(ptr_r, k)]) begin
                pick_s      = wrap_idx(ptr_r, k);
                any_valid_s = 1'b1;
            end else begin
                pick_s      = pick_s;
                any_valid_s = any_valid_s;
            end
        end
    end

    // Handshake and FIFO write port; rst gates them so a packet cut by reset
    // writes nothing more even in the reset cycle itself.
    always_comb begin
        req_ready  = '0;
        fifo_wen   = 1'b0;
        fifo_wdata = data_arr_s[grant_r];
        if ((state_r == ST_LOCK) && !rst) begin
            req_ready[grant_r] = ~fifo_full;
            fifo_wen           = owner_valid_s & ~fifo_full;
        end else begin
            req_ready = '0;
            fifo_wen  = 1'b0;
        end
    end

    // Arbitration FSM, grant/pointer registers and packet counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            ptr_r   <= ID_WIDTH'(NUM_REQ - 1);
            cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_valid_s) begin
                        grant_r <= pick_s;
                        state_r <= ST_LOCK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    if (beat_s && owner_last_s) begin
                        state_r <= ST_IDLE;
                        ptr_r   <= grant_r;
                        cnt_r   <= cnt_r + CNT_WIDTH'(1);
                    end else begin
                        state_r <= ST_LOCK;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_r == ST_LOCK);
    assign grant_id  = grant_r;
    assign pkt_count = cnt_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Cycle-level vector table for the arbitration / handshake rules, then
//   multi-cycle sequences driven by per-requester beat queues with an
//   expected-write scoreboard (owner id + data, in order).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int IW = 2;
    localparam int CW = 4;
    localparam int QD = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req_valid, req_last, req_ready;
    logic [NR*DW-1:0] req_data;
    logic           fifo_wen, fifo_full, busy;
    logic [DW-1:0]  fifo_wdata;
    logic [IW-1:0]  grant_id;
    logic [CW-1:0]  pkt_count;

    // stimulus sources: table (test process) or queue driver
    logic           drv_en;
    logic [NR-1:0]  drv_valid, drv_last, tbl_valid, tbl_last, stall;
    logic [NR*DW-1:0] drv_data, tbl_data;

    assign req_valid = drv_en ? drv_valid : tbl_valid;
    assign req_last  = drv_en ? drv_last  : tbl_last;
    assign req_data  = drv_en ? drv_data  : tbl_data;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
        .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    // ---------------- requester beat queues (driver owns rd, test owns wr)
    logic [DW-1:0] bq_data [NR][QD];
    logic          bq_last [NR][QD];
    int            bq_wr [NR];
    int            bq_rd [NR];
    logic [NR-1:0] acc_m;

    initial begin
        drv_valid = '0; drv_data = '0; drv_last = '0;
        for (int i = 0; i < NR; i++) bq_rd[i] = 0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (drv_en && acc_m[i] === 1'b1) bq_rd[i]++;
                drv_valid[i] = drv_en && (bq_rd[i] != bq_wr[i]) && !stall[i];
                drv_data[i*DW +: DW] = bq_data[i][bq_rd[i] % QD];
                drv_last[i] = bq_last[i][bq_rd[i] % QD];
            end
        end
    end

    // ---------------- write monitor (owns obs log, cycle counter, violations)
    typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] data; } wr_t;
    wr_t obs_q[$];
    int  obs_cyc[$];
    int  cyc;
    int  viol_cnt;

    initial begin
        cyc = 0; viol_cnt = 0; acc_m = '0;
        forever begin
            @(negedge clk);
            cyc++;
            acc_m = req_valid & req_ready;
            if (fifo_wen === 1'b1) begin
                obs_q.push_back('{grant_id, fifo_wdata});
                obs_cyc.push_back(cyc);
                if (fifo_full === 1'b1) viol_cnt++;
            end
        end
    end

    // ---------------- checking helpers
    int  n_pass = 0;
    int  n_total = 0;
    wr_t exp_q[$];
    int  obs_rd = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drain();
        wr_t o, e;
        while (obs_rd < obs_q.size()) begin
            o = obs_q[obs_rd];
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(o), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_owner", 32'(o.id), 32'(e.id));
                check("wr_data", 32'(o.data), 32'(e.data));
            end
            obs_rd++;
        end
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < NR; i++) if (bq_rd[i] != bq_wr[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_pkt(input int req, input logic [DW-1:0] base, input int nb);
        for (int b = 0; b < nb; b++) begin
            bq_data[req][bq_wr[req] % QD] = base + DW'(b);
            bq_last[req][bq_wr[req] % QD] = (b == nb - 1);
            bq_wr[req]++;
            exp_q.push_back('{IW'(req), base + DW'(b)});
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            tick();
            drain();
            done = queues_empty() && (busy === 1'b0) && (exp_q.size() == 0);
        end
        check({name, "_complete"}, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        drain();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    // ---------------- vector table
    typedef struct packed {
        logic [3:0] valid; logic [3:0] last; logic full;
        logic [3:0] ready; logic wen; logic busy; logic [1:0] grant;
        logic [3:0] cnt; logic chk_wd; logic [7:0] wdata;
    } vec_t;
    vec_t tbl [14];

    initial begin
        int base, vbase, n;
        rst = 1'b1; drv_en = 1'b0; fifo_full = 1'b0; stall = '0;
        tbl_valid = '0; tbl_last = '0;
        tbl_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        for (int i = 0; i < NR; i++) bq_wr[i] = 0;

        //            valid    last     full  ready    wen   busy  grant cnt   chkwd wdata
        tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00};
        tbl[1]  = '{4'b0110, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00};
        tbl[2]  = '{4'b0110, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 4'd0, 1'b1, 8'hB1};
        tbl[3]  = '{4'b0110, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 4'd0, 1'b1, 8'hB1};
        tbl[4]  = '{4'b0100, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 4'd0, 1'b1, 8'hB1};
        tbl[5]  = '{4'b0110, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 4'd0, 1'b1, 8'hB1};
        tbl[6]  = '{4'b0110, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 4'd1, 1'b0, 8'h00};
        tbl[7]  = '{4'b0110, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 4'd1, 1'b1, 8'hC2};
        tbl[8]  = '{4'b1001, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 4'd2, 1'b0, 8'h00};
        tbl[9]  = '{4'b1001, 4'b1001, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3, 4'd2, 1'b1, 8'hD3};
        tbl[10] = '{4'b1001, 4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3, 4'd2, 1'b1, 8'hD3};
        tbl[11] = '{4'b1001, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, 4'd3, 1'b0, 8'h00};
        tbl[12] = '{4'b1001, 4'b1001, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 4'd3, 1'b1, 8'hA0};
        tbl[13] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'd4, 1'b0, 8'h00};

        // reset state
        tick(); tick();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_wen", 32'(fifo_wen), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_count", 32'(pkt_count), 32'd0);
        rst = 1'b0;

        for (int r = 0; r < 14; r++) begin
            tbl_valid = tbl[r].valid; tbl_last = tbl[r].last; fifo_full = tbl[r].full;
            @(negedge clk);
            check($sformatf("row%0d_ready", r), 32'(req_ready), 32'(tbl[r].ready));
            check($sformatf("row%0d_wen", r), 32'(fifo_wen), 32'(tbl[r].wen));
            check($sformatf("row%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
            check($sformatf("row%0d_grant", r), 32'(grant_id), 32'(tbl[r].grant));
            check($sformatf("row%0d_count", r), 32'(pkt_count), 32'(tbl[r].cnt));
            if (tbl[r].chk_wd) check($sformatf("row%0d_wdata", r), 32'(fifo_wdata), 32'(tbl[r].wdata));
            tick();
        end
        tbl_valid = '0; fifo_full = 1'b0;
        drv_en = 1'b1;
        obs_rd = obs_q.size();     // table writes are not scoreboarded

        // A: single requester, 3-beat packet
        do_reset();
        base = obs_q.size();
        push_pkt(1, 8'd10, 3);
        tick();
        check("a_arb_busy", 32'(busy), 32'd0);
        check("a_arb_wen", 32'(fifo_wen), 32'd0);
        tick();
        check("a_grant", 32'(grant_id), 32'd1);
        check("a_busy", 32'(busy), 32'd1);
        check("a_wen0", 32'(fifo_wen), 32'd1);
        tick(); check("a_wen1", 32'(fifo_wen), 32'd1);
        tick(); check("a_wen2", 32'(fifo_wen), 32'd1);
        tick();
        check("a_busy_drop", 32'(busy), 32'd0);
        check("a_count", 32'(pkt_count), 32'd1);
        wait_idle("a", 20);
        check("a_writes", 32'(obs_q.size() - base), 32'd3);
        if (obs_q.size() - base == 3) check("a_span", 32'(obs_cyc[base+2] - obs_cyc[base]), 32'd2);

        // B: all requesters, 2-beat packets, order 0,1,2,3,0
        do_reset();
        base = obs_q.size();
        push_pkt(0, 8'h40, 2); push_pkt(1, 8'h50, 2); push_pkt(2, 8'h60, 2);
        push_pkt(3, 8'h70, 2); push_pkt(0, 8'h44, 2);
        wait_idle("b", 80);
        check("b_count", 32'(pkt_count), 32'd5);
        check("b_writes", 32'(obs_q.size() - base), 32'd10);
        if (obs_q.size() - base == 10) check("b_span", 32'(obs_cyc[base+9] - obs_cyc[base]), 32'd13);

        // C: backpressure for 3 cycles after beat 21
        do_reset();
        base = obs_q.size(); vbase = viol_cnt;
        push_pkt(0, 8'd20, 4);
        n = 0;
        while (obs_q.size() - base < 2 && n < 20) begin tick(); n++; end
        check("c_reach_21", 32'(obs_q.size() - base), 32'd2);
        fifo_full = 1'b1; #1;
        for (int k = 0; k < 3; k++) begin
            check("c_full_ready", 32'(req_ready[0]), 32'd0);
            check("c_full_wen", 32'(fifo_wen), 32'd0);
            tick();
        end
        fifo_full = 1'b0;
        wait_idle("c", 20);
        check("c_writes", 32'(obs_q.size() - base), 32'd4);
        check("c_wen_while_full", 32'(viol_cnt), 32'(vbase));

        // D: owner stalls mid-packet while req0 waits
        do_reset();
        base = obs_q.size();
        push_pkt(2, 8'h80, 4);
        n = 0;
        while (busy !== 1'b1 && n < 10) begin tick(); n++; end
        check("d_grant2", 32'(grant_id), 32'd2);
        push_pkt(0, 8'h90, 1);
        n = 0;
        while (obs_q.size() - base < 1 && n < 10) begin tick(); n++; end
        stall[2] = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            check("d_hold_grant", 32'(grant_id), 32'd2);
            check("d_hold_busy", 32'(busy), 32'd1);
            check("d_ready0", 32'(req_ready[0]), 32'd0);
            check("d_no_wen", 32'(fifo_wen), 32'd0);
        end
        stall[2] = 1'b0;
        wait_idle("d", 30);
        check("d_writes", 32'(obs_q.size() - base), 32'd5);

        // E: reset in the middle of req3's packet
        do_reset();
        push_pkt(1, 8'hB0, 1);
        wait_idle("e_pre", 10);
        base = obs_q.size();
        push_pkt(3, 8'hA0, 4);
        n = 0;
        while (obs_q.size() - base < 1 && n < 10) begin tick(); n++; end
        rst = 1'b1;
        drain();
        exp_q.delete();
        bq_wr[3] = bq_rd[3];        // requester abandons its packet
        #1;
        check("e_rst_wen", 32'(fifo_wen), 32'd0);
        tick();
        rst = 1'b0; #1;
        check("e_busy", 32'(busy), 32'd0);
        check("e_count", 32'(pkt_count), 32'd0);
        check("e_ready", 32'(req_ready), 32'd0);
        check("e_writes", 32'(obs_q.size() - base), 32'd1);
        push_pkt(0, 8'hE0, 1); push_pkt(3, 8'hE3, 1);
        tick(); tick();
        check("e_regrant0", 32'(grant_id), 32'd0);
        wait_idle("e", 20);

        // F: counter wraps at 16 in the CW=4 build
        do_reset();
        for (int p = 0; p < 17; p++) begin
            push_pkt(p % 4, 8'hC0 + DW'(p), 1);
            wait_idle("f", 10);
            check($sformatf("f_count%0d", p + 1), 32'(pkt_count), 32'((p + 1) % 16));
        end

        drain();
        check("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("end_wen_while_full", 32'(viol_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
